// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues reads to a synchronous instruction memory
// at the current PC and buffers the returned words, with their PCs, for
// decode over a valid/ready handshake. pc_advance tells the next-PC logic
// when a fetch was issued. flush discards everything queued or in flight.
module instr_fetch_queue #(
    parameter int ADDR_W  = 11,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_advance,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               flush,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    // Queue geometry sanity: pointer wrap relies on a power-of-two depth.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_fetch_queue: DEPTH must be a power of 2 and at least 2");
    end

    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_pc;

    logic               pop;
    logic               push;
    logic               issue;
    logic [OCC_W-1:0]   occupancy;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready & ~flush;
    // A response returning during a flush belongs to the old path and is dropped.
    assign push        = inflight & ~flush;

    // Occupancy seen by the next issue: queued entries plus the pending
    // return, minus the entry leaving this cycle. pop implies count >= 1,
    // so this never underflows.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue     = ~flush & (occupancy < OCC_W'(DEPTH));

    assign imem_en    = issue;
    assign pc_advance = issue;
    assign imem_addr  = pc_addr;

    // Head of queue comes straight from storage registers.
    assign instr    = q_instr[rd_ptr];
    assign instr_pc = q_pc[rd_ptr];

    // Control state: pointers, occupancy count and the in-flight tracker.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc_addr;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (flush) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage: returned word and its PC written at wr_ptr.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the entries are reset so instr/instr_pc read as zero after
        // reset; this is a small register array, not a RAM macro.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

`ifndef SYNTHESIS
    // A return into a full queue would overwrite the head; the issue rule
    // must make this unreachable.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CNT_W'(DEPTH))));
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a PC register and a 1-cycle
// instruction memory model (word = 0x1000_0000 + address).
module tb_instr_fetch_queue;

    localparam int ADDR_W  = 11;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [ADDR_W-1:0]  pc_addr;
    logic               pc_advance;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               flush = 1'b0;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready = 1'b0;
    logic [ADDR_W-1:0]  target = '0;

    int total = 0;
    int bad   = 0;
    int issues = 0;
    int base;

    instr_fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_advance(pc_advance),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .flush(flush), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // PC register: redirect on flush, increment when the fetch issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             pc_addr <= '0;
        else if (flush)      pc_addr <= target;
        else if (pc_advance) pc_addr <= pc_addr + 11'd1;
    end

    // Synchronous instruction memory with 1-cycle read latency.
    always_ff @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);
    end

    // Running count of issued fetches.
    always_ff @(posedge clk) begin
        if (!rst && pc_advance) issues <= issues + 1;
    end

    // Holds reset for two cycles, then releases it at a falling edge with
    // the given ready level; returns 1 time unit into cycle 0.
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; instr_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; instr_ready = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr); end
        total++; if (instr_pc !== 11'h0) begin bad++; $display("FAIL reset_instr_pc got=%h exp=0", instr_pc); end
        total++; if (pc_advance !== 1'b1) begin bad++; $display("FAIL reset_pc_advance got=%b exp=1", pc_advance); end
        total++; if (imem_addr !== pc_addr) begin bad++; $display("FAIL reset_imem_addr got=%h exp=%h", imem_addr, pc_addr); end
        flush = 1'b1;
        #1;
        total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL idle_flush_imem_en got=%b exp=0", imem_en); end
        flush = 1'b0;
        #1;
        total++; if (imem_en !== 1'b1) begin bad++; $display("FAIL idle_noflush_imem_en got=%b exp=1", imem_en); end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        total++; if (instr_valid !== 1'b0 || pc_advance !== 1'b1) begin bad++; $display("FAIL stream_c0 got valid=%b adv=%b exp valid=0 adv=1", instr_valid, pc_advance); end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk); #1;
            total++; if (pc_advance !== 1'b1) begin bad++; $display("FAIL stream_adv c%0d got=%b exp=1", k, pc_advance); end
            if (k == 1) begin
                total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_valid c1 got=%b exp=0", instr_valid); end
            end else begin
                total++; if (instr_valid !== 1'b1 || instr_pc !== 11'(k - 2) || instr !== 32'h1000_0000 + 32'(k - 2)) begin
                    bad++; $display("FAIL stream_head c%0d got=%b/%h/%h exp=1/%h/%h", k, instr_valid, instr_pc, instr, 11'(k - 2), 32'h1000_0000 + 32'(k - 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        base = issues;
        for (int k = 1; k < 6; k++) begin
            @(negedge clk); #1;
        end
        total++; if (issues - base !== 2) begin bad++; $display("FAIL bp_issues got=%0d exp=2", issues - base); end
        total++; if (pc_addr !== 11'd2 || pc_advance !== 1'b0) begin bad++; $display("FAIL bp_hold got pc=%h adv=%b exp pc=2 adv=0", pc_addr, pc_advance); end
        total++; if (dut.count !== 2'd2 || instr_pc !== 11'd0) begin bad++; $display("FAIL bp_full got count=%0d head=%h exp count=2 head=0", dut.count, instr_pc); end
        @(negedge clk); instr_ready = 1'b1; #1;
        total++; if (pc_advance !== 1'b1 || instr_pc !== 11'd0) begin bad++; $display("FAIL bp_pop got adv=%b head=%h exp adv=1 head=0", pc_advance, instr_pc); end
        @(negedge clk); instr_ready = 1'b0; #1;
        total++; if (pc_advance !== 1'b0 || instr_pc !== 11'd1 || dut.count !== 2'd1) begin
            bad++; $display("FAIL bp_after_pop got adv=%b head=%h count=%0d exp adv=0 head=1 count=1", pc_advance, instr_pc, dut.count);
        end
        @(negedge clk); #1;
        total++; if (issues - base !== 3 || dut.count !== 2'd2 || pc_addr !== 11'd3) begin
            bad++; $display("FAIL bp_one_issue got issues=%0d count=%0d pc=%h exp issues=3 count=2 pc=3", issues - base, dut.count, pc_addr);
        end
        @(negedge clk); instr_ready = 1'b1; #1;
        for (int k = 1; k <= 3; k++) begin
            total++; if (instr_valid !== 1'b1 || instr_pc !== 11'(k) || instr !== 32'h1000_0000 + 32'(k)) begin
                bad++; $display("FAIL bp_drain_%0d got=%b/%h/%h exp=1/%h/%h", k, instr_valid, instr_pc, instr, 11'(k), 32'h1000_0000 + 32'(k));
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_full_push_pop();
        do_reset(1'b0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); #1;
        end
        total++; if (dut.count !== 2'd2) begin bad++; $display("FAIL full_fill got count=%0d exp=2", dut.count); end
        @(negedge clk); instr_ready = 1'b1; #1;
        for (int k = 0; k < 8; k++) begin
            total++; if (instr_valid !== 1'b1 || instr_pc !== 11'(k) || instr !== 32'h1000_0000 + 32'(k) || dut.count > 2'd2) begin
                bad++; $display("FAIL full_stream_%0d got=%b/%h/%h count=%0d exp=1/%h/%h", k, instr_valid, instr_pc, instr, dut.count, 11'(k), 32'h1000_0000 + 32'(k));
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_flush_inflight();
        do_reset(1'b0);
        flush = 1'b1; target = 11'd4;
        @(negedge clk); flush = 1'b0; #1;
        total++; if (pc_addr !== 11'd4 || pc_advance !== 1'b1) begin bad++; $display("FAIL fl_redirect got pc=%h adv=%b exp pc=4 adv=1", pc_addr, pc_advance); end
        @(negedge clk); #1;
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 11'd4 || dut.inflight !== 1'b1) begin
            bad++; $display("FAIL fl_setup got valid=%b head=%h inflight=%b exp 1/4/1", instr_valid, instr_pc, dut.inflight);
        end
        flush = 1'b1; target = 11'h40; #1;
        total++; if (imem_en !== 1'b0 || pc_advance !== 1'b0) begin bad++; $display("FAIL fl_block got en=%b adv=%b exp 0/0", imem_en, pc_advance); end
        @(negedge clk); flush = 1'b0; #1;
        total++; if (instr_valid !== 1'b0 || pc_addr !== 11'h40 || pc_advance !== 1'b1) begin
            bad++; $display("FAIL fl_after got valid=%b pc=%h adv=%b exp 0/40/1", instr_valid, pc_addr, pc_advance);
        end
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fl_drop got valid=%b head=%h exp valid=0", instr_valid, instr_pc); end
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 11'h40 || instr !== 32'h1000_0040) begin
            bad++; $display("FAIL fl_resume got=%b/%h/%h exp=1/40/10000040", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_flush_with_ready();
        do_reset(1'b1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); #1;
        end
        flush = 1'b1; target = 11'h80; #1;
        total++; if (instr_valid !== 1'b1 || pc_advance !== 1'b0) begin bad++; $display("FAIL flr_setup got valid=%b adv=%b exp 1/0", instr_valid, pc_advance); end
        @(negedge clk); flush = 1'b0; #1;
        total++; if (instr_valid !== 1'b0 || dut.count !== 2'd0 || dut.rd_ptr !== dut.wr_ptr) begin
            bad++; $display("FAIL flr_empty got valid=%b count=%0d rd=%0d wr=%0d exp valid=0 count=0 rd=wr", instr_valid, dut.count, dut.rd_ptr, dut.wr_ptr);
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 11'h80 || instr !== 32'h1000_0080) begin
            bad++; $display("FAIL flr_resume got=%b/%h/%h exp=1/80/10000080", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        total++; if (dut.count !== 2'd1 || dut.inflight !== 1'b1) begin bad++; $display("FAIL ar_setup got count=%0d inflight=%b exp 1/1", dut.count, dut.inflight); end
        #2 rst = 1'b1;
        #1;
        total++; if (instr_valid !== 1'b0 || dut.count !== 2'd0 || dut.inflight !== 1'b0) begin
            bad++; $display("FAIL ar_immediate got valid=%b count=%0d inflight=%b exp 0/0/0", instr_valid, dut.count, dut.inflight);
        end
        @(negedge clk); rst = 1'b0; instr_ready = 1'b1; #1;
        total++; if (pc_addr !== 11'd0 || pc_advance !== 1'b1 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL ar_restart got pc=%h adv=%b valid=%b exp 0/1/0", pc_addr, pc_advance, instr_valid);
        end
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ar_stale got valid=%b head=%h exp valid=0", instr_valid, instr_pc); end
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 11'd0 || instr !== 32'h1000_0000) begin
            bad++; $display("FAIL ar_first got=%b/%h/%h exp=1/0/10000000", instr_valid, instr_pc, instr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_push_pop();
        test_flush_inflight();
        test_flush_with_ready();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
